// File: rtl/interrupt_register.sv
// CPU-visible interrupt register bank: sticky pending bits, enable mask and
// per-source saturating event counters behind a registered read port.
module interrupt_register #(
   parameter int CW = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        activintreg,
   input  logic        irqsucrec,
   input  logic        irqsuctra,
   input  logic        irqstatus,
   input  logic        wr,
   input  logic        rd,
   input  logic [1:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic [2:0]  irqstd,
   output logic [2:0]  ienable
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [2:0]    irqstd_reg, irqstd_next;
   logic [2:0]    ienable_reg, ienable_next;
   logic [15:0]   rdata_reg, rdata_next;
   logic [CW-1:0] cnt_reg  [3];
   logic [CW-1:0] cnt_next [3];
   logic [2:0]    set_vec;
   logic [2:0]    rd_clr;
   logic          wr_irq;

   assign set_vec = {irqstatus, irqsuctra, irqsucrec} & {3{activintreg}};
   assign wr_irq  = wr && (addr == 2'd0);

   // Set wins over a same-cycle write-1-to-clear.
   assign irqstd_next  = set_vec | (irqstd_reg & ~(wdata[2:0] & {3{wr_irq}}));
   assign ienable_next = wr_irq ? wdata[10:8] : ienable_reg;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         assign rd_clr[gi] = rd && (addr == 2'(gi + 1));
         // A read-clear racing a set event leaves a count of one.
         assign cnt_next[gi] = rd_clr[gi] ? CW'(set_vec[gi]) :
                               (set_vec[gi] && (cnt_reg[gi] != CNT_MAX)) ? cnt_reg[gi] + CW'(1) :
                               cnt_reg[gi];
      end
   endgenerate

   always_comb begin
      rdata_next = rdata_reg;
      if (rd) begin
         case (addr)
            2'd0:    rdata_next = {5'b0, ienable_reg, 5'b0, irqstd_reg};
            2'd1:    rdata_next = 16'(cnt_reg[0]);
            2'd2:    rdata_next = 16'(cnt_reg[1]);
            default: rdata_next = 16'(cnt_reg[2]);
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irqstd_reg  <= '0;
         ienable_reg <= '0;
         rdata_reg   <= '0;
         for (int i = 0; i < 3; i++) cnt_reg[i] <= '0;
      end else begin
         irqstd_reg  <= irqstd_next;
         ienable_reg <= ienable_next;
         rdata_reg   <= rdata_next;
         for (int i = 0; i < 3; i++) cnt_reg[i] <= cnt_next[i];
      end
   end

   assign irqstd  = irqstd_reg;
   assign ienable = ienable_reg;
   assign rdata   = rdata_reg;

endmodule

// File: tb/tb_interrupt_register.sv
// Directed bench for interrupt_register with hand-computed expectations.
module tb_interrupt_register;

   logic        clock = 1'b0;
   logic        reset;
   logic        activintreg, irqsucrec, irqsuctra, irqstatus;
   logic        wr, rd;
   logic [1:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic [2:0]  irqstd, ienable;

   int checks = 0;
   int errors = 0;

   interrupt_register #(.CW(8)) dut (
      .clock(clock), .reset(reset), .activintreg(activintreg),
      .irqsucrec(irqsucrec), .irqsuctra(irqsuctra), .irqstatus(irqstatus),
      .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
      .rdata(rdata), .irqstd(irqstd), .ienable(ienable)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%04h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      activintreg = 0; irqsucrec = 0; irqsuctra = 0; irqstatus = 0;
      wr = 0; rd = 0;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [15:0] d);
      wr = 1; addr = a; wdata = d;
      step();
   endtask

   task automatic do_read(input logic [1:0] a);
      rd = 1; addr = a;
      step();
   endtask

   task automatic pulse(input logic [2:0] src);
      activintreg = 1; {irqstatus, irqsuctra, irqsucrec} = src;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0; activintreg = 0; irqsucrec = 0; irqsuctra = 0; irqstatus = 0;
      wr = 0; rd = 0; addr = 0; wdata = 0;
      #23 reset = 1;
      @(posedge clock); #1;
      check("reset_irqstd", 16'(irqstd), 16'h0);
      check("reset_ienable", 16'(ienable), 16'h0);
      check("reset_rdata", rdata, 16'h0);

      // Receive set, counter read-clear, W1C
      do_write(2'd0, 16'h0700);
      check("en_all", 16'(ienable), 16'h7);
      pulse(3'b001);
      check("rec_set", 16'(irqstd), 16'h1);
      do_read(2'd1);
      check("cntrec_1", rdata, 16'h0001);
      do_read(2'd1);
      check("cntrec_cleared", rdata, 16'h0000);
      do_write(2'd0, 16'h0701);
      check("rec_w1c", 16'(irqstd), 16'h0);
      check("rec_w1c_en", 16'(ienable), 16'h7);
      do_read(2'd0);
      check("irqreg_read", rdata, 16'h0700);

      // Set vs W1C collision
      pulse(3'b010);
      check("tra_set", 16'(irqstd), 16'h2);
      activintreg = 1; irqsuctra = 1;
      do_write(2'd0, 16'h0702);
      check("collide_keep", 16'(irqstd), 16'h2);
      do_read(2'd2);
      check("cnttra_2", rdata, 16'h0002);

      // Saturation and read-clear race
      for (int i = 0; i < 300; i++) pulse(3'b100);
      check("stat_pending", 16'(irqstd), 16'h6);
      do_read(2'd3);
      check("cntstat_sat", rdata, 16'h00FF);
      for (int i = 0; i < 4; i++) pulse(3'b100);
      activintreg = 1; irqstatus = 1;
      do_read(2'd3);
      check("race_old", rdata, 16'h0004);
      do_read(2'd3);
      check("race_after", rdata, 16'h0001);

      // Multi-hot set, then simultaneous rd/wr
      do_write(2'd0, 16'h0707);
      check("clear_all", 16'(irqstd), 16'h0);
      pulse(3'b101);
      check("multi_set", 16'(irqstd), 16'h5);
      rd = 1; wr = 1; addr = 2'd0; wdata = 16'h0005;
      step();
      check("rdwr_rdata", rdata, 16'h0705);
      check("rdwr_irqstd", 16'(irqstd), 16'h0);
      check("rdwr_ienable", 16'(ienable), 16'h0);

      // Indications without strobe ignored; counter writes ignored
      irqsucrec = 1;
      step();
      check("no_strobe", 16'(irqstd), 16'h0);
      do_write(2'd1, 16'hFFFF);
      check("wr_cnt_ign_std", 16'(irqstd), 16'h0);
      check("wr_cnt_ign_en", 16'(ienable), 16'h0);
      do_read(2'd1);
      check("cntrec_multi", rdata, 16'h0001);
      step(); step();
      check("rdata_hold", rdata, 16'h0001);

      // Disable keeps pending
      do_write(2'd0, 16'h0400);
      check("en_stat", 16'(ienable), 16'h4);
      pulse(3'b100);
      do_write(2'd0, 16'h0000);
      check("dis_en", 16'(ienable), 16'h0);
      check("dis_pending", 16'(irqstd), 16'h4);
      do_read(2'd0);
      check("dis_read", rdata, 16'h0004);

      // Asynchronous reset mid-access
      rd = 1; addr = 2'd3;
      #2 reset = 0;
      #1;
      check("areset_irqstd", 16'(irqstd), 16'h0);
      check("areset_rdata", rdata, 16'h0);
      rd = 0;
      @(negedge clock) reset = 1;
      step();
      do_read(2'd3);
      check("post_reset_cnt", rdata, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/interrupt_register.md
# interrupt_register

CPU-visible interrupt register bank that sits directly downstream of the interrupt unit and closes its feedback loop. It captures the unit's one-cycle indications (`activintreg` with `irqsucrec`/`irqsuctra`/`irqstatus`) into sticky pending bits. It holds the CPU-written enable mask and keeps per-source saturating event counters. It returns `irqstd` and `ienable` to the interrupt unit and serves CPU reads and writes with a registered read path.

## Interface
- `CW`, 8, width of each event counter (saturating).
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `activintreg`  in  1  update strobe from the interrupt unit.
- `irqsucrec`  in  1  receive indication; valid only with `activintreg`.
- `irqsuctra`  in  1  transmit indication; valid only with `activintreg`.
- `irqstatus`  in  1  status-change indication; valid only with `activintreg`.
- `wr`  in  1  CPU write strobe, one cycle per access.
- `rd`  in  1  CPU read strobe, one cycle per access.
- `addr`  in  2  register select.
- `wdata`  in  16  CPU write data.
- `rdata`  out  16  registered read data.
- `irqstd`  out  3  pending bits [0]=rec, [1]=tra, [2]=status; feeds the interrupt unit.
- `ienable`  out  3  enable mask, same bit order; feeds the interrupt unit.

## Operation
- Register map:
  - addr 0 = IRQREG: rdata[2:0]=`irqstd`, rdata[10:8]=`ienable`, all other bits 0.
  - addr 1 = CNTREC, addr 2 = CNTTRA, addr 3 = CNTSTAT: rdata[CW-1:0]=count, upper bits 0.
- Set events:
  - `activintreg`=1 & `irqsucrec`=1 sets `irqstd`[0]; `irqsuctra` sets [1]; `irqstatus` sets [2].
  - Indications are one-hot. If more than one is high, each corresponding bit is set independently; no priority.
  - Indications while `activintreg`=0 are ignored.
- Write to IRQREG:
  - `ienable` <= `wdata`[10:8].
  - `irqstd`[i] cleared where `wdata`[i]=1 (write-1-to-clear); bits with `wdata`[i]=0 are unchanged.
- Set and clear of the same pending bit in the same cycle: set wins, bit stays 1.
- Clearing an `ienable` bit does not clear a pending `irqstd` bit; the CPU must clear it explicitly.
- Writes to addr 1-3 are ignored.
- Counters:
  - Each counter increments by 1 on every set event of its source, counted even if the pending bit is already 1.
  - Saturates at 2^CW-1; no wrap.
- Read-clear: a read of addr 1-3 zeroes that counter after sampling.
  - If a set event for the same source occurs in the read cycle, the counter becomes 1, not 0. The read still returns the pre-event value.
- `rd` and `wr` in the same cycle: both execute; `rdata` returns the pre-write value.

## Timing
- Reset (asynchronous, immediate): `irqstd`=000, `ienable`=000, all counters 0, `rdata`=0.
- Set event in cycle n: `irqstd` bit and counter visible from cycle n+1.
- Write in cycle n: new `ienable`/`irqstd` visible from cycle n+1.
- Read latency is 1 cycle:
  - `rd` in cycle n makes `rdata` valid in n+1.
  - `rdata` holds its value until the next `rd`.
- Back-to-back reads every cycle are supported, one result per cycle.
- Reset asserted mid-access: the access is aborted and no partial update remains. The first cycle after reset release behaves like a fresh idle cycle.
- `irqstd`/`ienable` are registered outputs with no combinational path from any input, which keeps the interrupt unit's next-state logic free of loops.

## Test plan
- **Reset values:** drive `reset`=0 mid-cycle -> all outputs 0 immediately, without waiting for a `clock` edge.
- **Rec set and clear:**
  - `ienable`=111 via write 0x0700; one cycle `activintreg`=1, `irqsucrec`=1 -> next cycle `irqstd`=001.
  - Read addr 1 -> `rdata`=0x0001, after which CNTREC=0.
  - Write 0x0701 -> `irqstd`=000, `ienable` remains 111.
- **Set vs W1C collision:** with `irqstd`[1]=1, in the same cycle write 0x0702 and pulse `irqsuctra` -> `irqstd`[1] stays 1 and CNTTRA increments.
- **Saturation and read-clear race:**
  - Pulse `irqstatus` 300 times -> read addr 3 returns 0x00FF.
  - Read in the same cycle as a status event -> `rdata` shows the old count and CNTSTAT=1 afterwards.
- **Simultaneous rd/wr:** with `irqstd`=101, issue `rd`+`wr` to addr 0 with `wdata`=0x0005 in one cycle -> `rdata`[2:0]=101 and `irqstd`=000 from the next cycle.
- **Disable keeps pending:** with `irqstd`[2]=1, write 0x0000 -> `ienable`=000 and `irqstd`=100 unchanged.
